i2c_addr_master: RTL

- System-clocked I2C initiator that drives the opposite end of the bus from the address pattern detector.
- Generates SCL, START, a 7-bit address plus R/W bit, samples the target ACK, optionally writes one data byte, then issues STOP.
- Used in the I2C subsystem as the stimulus/controller side for address-detecting responders.

---
 rtl/i2c_addr_master_if.sv | 30 +++
 rtl/i2c_addr_master.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/i2c_addr_master_if.sv
// Bus bundle between the I2C address master and its requester.
// Request side: start is a one-cycle pulse. It is accepted only when the master
// is idle and not pulsing done. addr/rw/data_en/wr_data are sampled on that
// same edge. busy rises the cycle after acceptance. done pulses for one cycle
// when the master returns to idle; nack is valid with done and holds until the
// next accept.
interface i2c_addr_master_if;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic       data_en;
  logic [7:0] wr_data;
  logic       SDA_in;
  logic       SCL_out;
  logic       SDA_out;
  logic       busy;
  logic       done;
  logic       nack;
  logic [2:0] state_dbg;

  modport master (
    input  start, addr, rw, data_en, wr_data, SDA_in,
    output SCL_out, SDA_out, busy, done, nack, state_dbg
  );

  modport slave (
    output start, addr, rw, data_en, wr_data, SDA_in,
    input  SCL_out, SDA_out, busy, done, nack, state_dbg
  );
endinterface

// File: rtl/i2c_addr_master.sv
// I2C initiator: START, 7-bit address + R/W, ACK sample, optional data byte
// with ACK sample, then STOP. One bit period is four quarters of CLK_DIV clocks.
module i2c_addr_master #(
  parameter int ADDRESS_WIDTH = 7,
  parameter int CLK_DIV       = 4
) (
  input logic              clk,
  input logic              rst_n,
  i2c_addr_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_ADDR     = 3'd2,
    S_ADDR_ACK = 3'd3,
    S_DATA     = 3'd4,
    S_DATA_ACK = 3'd5,
    S_STOP     = 3'd6
  } state_t;

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t                 state, state_next;
  logic [QW-1:0]          qcnt;
  logic [1:0]             quarter;
  logic [2:0]             bit_cnt;
  logic [ADDRESS_WIDTH:0] shreg;
  logic [7:0]             data_r;
  logic                   data_en_r;
  logic                   ack_bad;
  logic                   nack_r;
  logic                   done_r;

  logic tick_end;
  logic bit_end;
  logic sample_pt;
  logic accept;
  logic in_ack;

  // A pulse that coincides with done is refused: the transfer has not yet
  // been reported complete to the requester.
  assign tick_end  = (qcnt == QW'(CLK_DIV - 1));
  assign bit_end   = tick_end && (quarter == 2'd3);
  assign sample_pt = (quarter == 2'd3) && (qcnt == '0);
  assign in_ack    = (state == S_ADDR_ACK) || (state == S_DATA_ACK);
  assign accept    = (state == S_IDLE) && bus.start && !done_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode; every non-idle state advances only at a bit boundary.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (accept) state_next = S_START;
      S_START:    if (bit_end) state_next = S_ADDR;
      S_ADDR:     if (bit_end && bit_cnt == 3'd7) state_next = S_ADDR_ACK;
      S_ADDR_ACK: if (bit_end) state_next = (!ack_bad && data_en_r) ? S_DATA : S_STOP;
      S_DATA:     if (bit_end && bit_cnt == 3'd7) state_next = S_DATA_ACK;
      S_DATA_ACK: if (bit_end) state_next = S_STOP;
      S_STOP:     if (bit_end) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Bus drive and status decode from state and quarter position.
  always_comb begin
    bus.SCL_out   = 1'b1;
    bus.SDA_out   = 1'b1;
    bus.busy      = (state != S_IDLE);
    bus.done      = done_r;
    bus.nack      = nack_r;
    bus.state_dbg = state;
    case (state)
      S_START: bus.SDA_out = !quarter[1];
      S_ADDR, S_DATA: begin
        bus.SCL_out = quarter[1];
        bus.SDA_out = shreg[ADDRESS_WIDTH];
      end
      S_ADDR_ACK, S_DATA_ACK: bus.SCL_out = quarter[1];
      S_STOP: begin
        bus.SCL_out = quarter[1];
        bus.SDA_out = (quarter == 2'd3);
      end
      default: ;
    endcase
  end

  // Quarter/clock/bit counters; held at zero while idle.
  always_ff @(posedge clk) begin
    if (!rst_n || state == S_IDLE) begin
      qcnt    <= '0;
      quarter <= 2'd0;
      bit_cnt <= 3'd0;
    end else begin
      if (tick_end) begin
        qcnt    <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        qcnt <= qcnt + 1'b1;
      end
      if (bit_end && (state == S_ADDR || state == S_DATA))
        bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Request capture, shift register, ACK sampling and completion status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      data_r    <= 8'd0;
      data_en_r <= 1'b0;
      ack_bad   <= 1'b0;
      nack_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= (state == S_STOP) && bit_end;
      if (accept) begin
        shreg     <= {bus.addr, bus.rw};
        data_r    <= bus.wr_data;
        data_en_r <= bus.data_en;
        ack_bad   <= 1'b0;
        nack_r    <= 1'b0;
      end
      if (in_ack && sample_pt) begin
        ack_bad <= bus.SDA_in;
        if (bus.SDA_in) nack_r <= 1'b1;
      end
      if (bit_end) begin
        if (state == S_ADDR || state == S_DATA)
          shreg <= {shreg[ADDRESS_WIDTH-1:0], 1'b0};
        else if (state == S_ADDR_ACK)
          shreg <= data_r;
      end
    end
  end

endmodule
